// File: rtl/buffer_module.sv
// rtl/buffer_module.sv - synchronous FIFO buffer with registered read data, clear and async reset
// Occupancy counter drives full/empty; a read frees its slot in the same edge, so write-while-full with read succeeds.
module buffer_module #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             write_en,
  input  logic             read_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_read;
  logic             do_write;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_read  = read_en && !empty;
  assign do_write = write_en && (!full || do_read);

  // Storage is not reset; stale words are unreachable once pointers are zeroed.
  always_ff @(posedge CLK) begin
    if (!nRST && !clear && do_write) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_module.sv
// tb/tb_buffer_module.sv - directed self-checking bench for buffer_module (WIDTH=32, DEPTH=8)
module tb_buffer_module;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             CLK;
  logic             nRST;
  logic             write_en;
  logic             read_en;
  logic             clear;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;

  int checks;
  int errors;

  buffer_module #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .write_en(write_en), .read_en(read_en),
    .clear(clear), .din(din), .dout(dout), .full(full), .empty(empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] data);
    write_en = 1'b1;
    read_en  = 1'b0;
    din      = data;
    step();
    write_en = 1'b0;
  endtask

  task automatic rd();
    write_en = 1'b0;
    read_en  = 1'b1;
    step();
    read_en  = 1'b0;
  endtask

  task automatic wr_rd(input logic [31:0] data);
    write_en = 1'b1;
    read_en  = 1'b1;
    din      = data;
    step();
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    nRST     = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    clear    = 1'b0;
    din      = '0;
    #3;
    check("reset_dout", dout, 0);
    check("reset_empty", {31'd0, empty}, 1);
    check("reset_full", {31'd0, full}, 0);
    @(negedge CLK);
    nRST = 1'b0;

    // Basic ordered write then read
    for (int i = 1; i <= 6; i++) begin
      wr(i * 100);
      if (i == 1) check("first_write_empty", {31'd0, empty}, 0);
    end
    for (int i = 1; i <= 6; i++) begin
      rd();
      check($sformatf("seq_read_%0d", i), dout, i * 100);
    end
    check("seq_drained_empty", {31'd0, empty}, 1);

    // Fill to full, drop write while full, drain
    for (int i = 1; i <= 8; i++) begin
      wr(i * 10);
      if (i == 7) check("seven_not_full", {31'd0, full}, 0);
    end
    check("eight_full", {31'd0, full}, 1);
    wr(9999);
    check("write_when_full_full", {31'd0, full}, 1);
    check("write_when_full_dout", dout, 600);
    for (int i = 1; i <= 8; i++) begin
      rd();
      check($sformatf("full_drain_%0d", i), dout, i * 10);
      if (i == 1) check("after_pop_not_full", {31'd0, full}, 0);
    end
    check("full_drain_empty", {31'd0, empty}, 1);

    // Read while empty holds dout and does not underflow
    rd();
    check("empty_read_dout", dout, 80);
    check("empty_read_empty", {31'd0, empty}, 1);
    wr(5);
    check("one_entry_not_empty", {31'd0, empty}, 0);
    rd();
    check("one_entry_read", dout, 5);
    check("one_entry_empty", {31'd0, empty}, 1);

    // Simultaneous write and read at partial occupancy
    wr(40);
    wr_rd(80);
    check("wr_rd_0", dout, 40);
    wr_rd(120);
    check("wr_rd_1", dout, 80);
    wr_rd(160);
    check("wr_rd_2", dout, 120);
    check("wr_rd_not_empty", {31'd0, empty}, 0);
    rd();
    check("wr_rd_tail", dout, 160);
    check("wr_rd_then_empty", {31'd0, empty}, 1);

    // Pointer wrap: three preloaded, twelve simultaneous pairs, drain three
    for (int i = 0; i < 3; i++) wr(1000 + i);
    for (int i = 0; i < 12; i++) begin
      wr_rd(1003 + i);
      check($sformatf("wrap_pair_%0d", i), dout, 1000 + i);
      check($sformatf("wrap_flags_%0d", i), {30'd0, full, empty}, 0);
    end
    for (int i = 0; i < 3; i++) begin
      rd();
      check($sformatf("wrap_drain_%0d", i), dout, 1012 + i);
    end
    check("wrap_empty", {31'd0, empty}, 1);

    // Simultaneous write and read while full
    for (int i = 0; i < 8; i++) wr(2000 + i);
    check("fill2_full", {31'd0, full}, 1);
    wr_rd(2008);
    check("full_wr_rd_dout", dout, 2000);
    check("full_wr_rd_full", {31'd0, full}, 1);
    for (int i = 1; i <= 8; i++) begin
      rd();
      check($sformatf("full_wr_rd_drain_%0d", i), dout, 2000 + i);
    end
    check("full_wr_rd_empty", {31'd0, empty}, 1);

    // Clear overrides write and read
    for (int i = 0; i < 3; i++) wr(300 + i);
    clear    = 1'b1;
    write_en = 1'b1;
    read_en  = 1'b1;
    din      = 77;
    step();
    clear    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    check("clear_empty", {31'd0, empty}, 1);
    check("clear_full", {31'd0, full}, 0);
    check("clear_dout", dout, 0);
    rd();
    check("clear_no_capture_dout", dout, 0);
    check("clear_no_capture_empty", {31'd0, empty}, 1);
    wr(11);
    rd();
    check("after_clear_read", dout, 11);

    // Asynchronous reset between edges
    wr(22);
    wr(33);
    rd();
    check("pre_reset_dout", dout, 22);
    #2;
    nRST = 1'b1;
    #1;
    check("async_reset_dout", dout, 0);
    check("async_reset_empty", {31'd0, empty}, 1);
    wr(55);
    check("reset_held_write_ignored", {31'd0, empty}, 1);
    @(negedge CLK);
    nRST = 1'b0;
    rd();
    check("reset_discard_dout", dout, 0);
    check("reset_discard_empty", {31'd0, empty}, 1);
    wr(44);
    rd();
    check("post_reset_read", dout, 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
